// File: rtl/prefetch_queue_if.sv
// Handshake bundle between the prefetch queue, the bus interface and the decoder.
// The master view belongs to the queue itself; the slave view belongs to its environment.
interface prefetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   cs;
    logic          flush;
    logic [15:0]   flush_ip;
    logic          mem_req;
    logic [19:0]   mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_rdata;
    logic          q_valid;
    logic [7:0]    q_byte;
    logic [15:0]   q_ip;
    logic          q_pop;
    logic [CW-1:0] q_count;

    modport master (
        input  cs, flush, flush_ip, mem_ack, mem_rdata, q_pop,
        output mem_req, mem_addr, q_valid, q_byte, q_ip, q_count
    );

    modport slave (
        output cs, flush, flush_ip, mem_ack, mem_rdata, q_pop,
        input  mem_req, mem_addr, q_valid, q_byte, q_ip, q_count
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches aligned words at CS*16+IP and buffers
// bytes for the decoder; flushed and re-pointed on every control transfer.
module prefetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_reg, state_next;
    logic [15:0]   head_ip_reg, head_ip_next;
    logic [15:0]   fetch_ip_reg, fetch_ip_next;
    logic          discard_reg, discard_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          mem_req_reg, mem_req_next;
    logic [19:0]   mem_addr_reg, mem_addr_next;

    logic [7:0]    buffer [DEPTH];
    logic [PW-1:0] wr_ptr_inc;
    logic [CW-1:0] free_space;
    logic          can_issue;
    logic          pop;
    logic          ack_fire;
    logic          we0, we1;
    logic [7:0]    wdata0, wdata1;
    logic [1:0]    n_push;

    assign wr_ptr_inc = wr_ptr_reg + 1'b1;
    assign free_space = CW'(DEPTH) - count_reg;
    // An odd fetch_ip only ever yields one byte, so one free slot is enough.
    assign can_issue  = (free_space >= CW'(2)) || ((free_space != '0) && fetch_ip_reg[0]);
    assign pop        = bus.q_pop && (count_reg != '0);
    assign ack_fire   = (state_reg == WAIT) && bus.mem_ack;

    always_comb begin
        state_next    = state_reg;
        head_ip_next  = head_ip_reg;
        fetch_ip_next = fetch_ip_reg;
        discard_next  = discard_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        we0           = 1'b0;
        we1           = 1'b0;
        wdata0        = bus.mem_rdata[7:0];
        wdata1        = bus.mem_rdata[15:8];
        n_push        = 2'd0;

        if (ack_fire) begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
            discard_next = 1'b0;
        end

        if (bus.flush) begin
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            head_ip_next  = bus.flush_ip;
            fetch_ip_next = bus.flush_ip;
            // A request still in flight must have its data thrown away on arrival.
            if ((state_reg == WAIT) && !bus.mem_ack) begin
                discard_next = 1'b1;
            end
        end else begin
            if (ack_fire && !discard_reg) begin
                if (fetch_ip_reg[0]) begin
                    we0           = 1'b1;
                    wdata0        = bus.mem_rdata[15:8];
                    n_push        = 2'd1;
                    fetch_ip_next = fetch_ip_reg + 16'd1;
                end else begin
                    we0           = 1'b1;
                    we1           = 1'b1;
                    n_push        = 2'd2;
                    fetch_ip_next = fetch_ip_reg + 16'd2;
                end
            end
            if ((state_reg == IDLE) && can_issue) begin
                state_next    = WAIT;
                mem_req_next  = 1'b1;
                mem_addr_next = {bus.cs, 4'h0} + {4'h0, fetch_ip_reg & 16'hFFFE};
            end
            if (pop) begin
                rd_ptr_next  = rd_ptr_reg + 1'b1;
                head_ip_next = head_ip_reg + 16'd1;
            end
            wr_ptr_next = wr_ptr_reg + PW'(n_push);
            count_next  = count_reg + CW'(n_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            head_ip_reg  <= 16'h0000;
            fetch_ip_reg <= 16'h0000;
            discard_reg  <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= 20'h00000;
        end else begin
            state_reg    <= state_next;
            head_ip_reg  <= head_ip_next;
            fetch_ip_reg <= fetch_ip_next;
            discard_reg  <= discard_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

    // Byte storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (we0) begin
            buffer[wr_ptr_reg] <= wdata0;
        end
        if (we1) begin
            buffer[wr_ptr_inc] <= wdata1;
        end
    end

    assign bus.mem_req  = mem_req_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.q_valid  = (count_reg != '0);
    assign bus.q_byte   = buffer[rd_ptr_reg];
    assign bus.q_ip     = head_ip_reg;
    assign bus.q_count  = count_reg;
endmodule
